// File: rtl/ama_riscv_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: PC select codes,
// the injected NOP and the fetch FSM state encoding.
package ama_riscv_fetch_pkg;

    localparam logic [1:0] PC_SEL_INC   = 2'd0;
    localparam logic [1:0] PC_SEL_ALU   = 2'd1;
    localparam logic [1:0] PC_SEL_BP    = 2'd2;
    localparam logic [1:0] PC_SEL_START = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_RST  = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ama_riscv_fetch_buffer.sv
// Single-entry holding register for a fetched instruction and its PC,
// used when a response lands while ID is stalled.
module ama_riscv_fetch_buffer
    import ama_riscv_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain || flush) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst <= NOP_INST;
            pc   <= '0;
        end else if (load) begin
            inst <= load_inst;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests
// to instruction memory and feeds the IF/ID register.
module ama_riscv_fetch
    import ama_riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP       = NOP_INST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   pc_sel,
    input  logic         pc_we,
    input  logic         stall_if,
    input  logic         clear_if,
    input  logic [31:0]  alu_out,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  inst_id,
    output logic [31:0]  pc_id,
    output logic         inst_valid_id,
    output logic         fetch_busy,
    output fetch_state_t state_dbg
);

    // Request channel: a request transfers on a cycle where imem_req and
    // imem_ready are both high; imem_req/imem_addr stay stable until then.
    // Response channel has no backpressure: one imem_rvalid pulse per
    // accepted request, in order.

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_inc, target, issue_addr;
    logic         kill, kill_nxt;
    logic         redirect, accept;
    logic         rsp_live, rsp_advance, rsp_to_id;
    logic         buf_load, buf_drain, buf_flush, buf_valid, buf_to_id;
    logic [31:0]  buf_inst, buf_pc;

    assign redirect   = pc_we && (pc_sel == PC_SEL_ALU || pc_sel == PC_SEL_START);
    assign target     = (pc_sel == PC_SEL_START) ? RESET_VEC : word_align(alu_out);
    assign pc_inc     = pc + 32'd4;
    assign issue_addr = redirect ? target : ((state == FETCH_WAIT) ? pc_inc : pc);
    assign accept     = imem_req && imem_ready;

    // A live response is one that belongs to the current PC stream.
    assign rsp_live    = (state == FETCH_WAIT) && imem_rvalid && !kill;
    assign rsp_advance = rsp_live && (clear_if || !stall_if);
    assign rsp_to_id   = rsp_live && !clear_if && !stall_if;
    assign buf_to_id   = buf_valid && !redirect && !clear_if && !stall_if;

    assign state_dbg  = state;
    assign fetch_busy = !(rsp_live || buf_valid) && !stall_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_RST;
            pc    <= RESET_VEC;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_flush = 1'b0;
        case (state)
            FETCH_RST: begin
                state_nxt = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (accept) begin
                    pc_nxt    = issue_addr;
                    state_nxt = FETCH_WAIT;
                end else if (redirect) begin
                    pc_nxt = target;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid && kill) begin
                    kill_nxt  = 1'b0;
                    state_nxt = FETCH_REQ;
                    if (redirect) pc_nxt = target;
                end else if (rsp_advance) begin
                    pc_nxt    = issue_addr;
                    state_nxt = accept ? FETCH_WAIT : FETCH_REQ;
                end else if (rsp_live && redirect) begin
                    // stalled response on a path being abandoned: drop it
                    pc_nxt    = target;
                    state_nxt = FETCH_REQ;
                end else if (rsp_live) begin
                    buf_load  = 1'b1;
                    state_nxt = FETCH_HOLD;
                end else if (redirect) begin
                    kill_nxt = 1'b1;
                    pc_nxt   = target;
                end
            end
            FETCH_HOLD: begin
                if (redirect) begin
                    buf_flush = 1'b1;
                    pc_nxt    = target;
                    state_nxt = FETCH_REQ;
                end else if (clear_if || !stall_if) begin
                    buf_drain = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = FETCH_REQ;
                end
            end
            default: begin
                state_nxt = FETCH_RST;
            end
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH_REQ:  imem_req = pc_we;
            FETCH_WAIT: imem_req = pc_we && rsp_advance;
            default:    imem_req = 1'b0;
        endcase
        if (rst) imem_req = 1'b0;
        imem_addr = issue_addr;
    end

    ama_riscv_fetch_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .drain     (buf_drain),
        .flush     (buf_flush),
        .load_inst (imem_rdata),
        .load_pc   (pc),
        .valid     (buf_valid),
        .inst      (buf_inst),
        .pc        (buf_pc)
    );

    // IF/ID register: clear beats stall beats load
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_id       <= NOP;
            pc_id         <= '0;
            inst_valid_id <= 1'b0;
        end else if (clear_if) begin
            inst_id       <= NOP;
            inst_valid_id <= 1'b0;
        end else if (!stall_if) begin
            if (rsp_to_id) begin
                inst_id       <= imem_rdata;
                pc_id         <= pc;
                inst_valid_id <= 1'b1;
            end else if (buf_to_id) begin
                inst_id       <= buf_inst;
                pc_id         <= buf_pc;
                inst_valid_id <= 1'b1;
            end else begin
                inst_id       <= NOP;
                inst_valid_id <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Bench for ama_riscv_fetch: directed scenarios against a variable-latency
// memory, a transaction-level fetch model checked every cycle, and literal pins.
module tb_ama_riscv_fetch;
    import ama_riscv_fetch_pkg::*;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic         clk, rst, pc_we, stall_if, clear_if;
    logic [1:0]   pc_sel;
    logic [31:0]  alu_out, imem_addr, imem_rdata, inst_id, pc_id;
    logic         imem_req, imem_ready, imem_rvalid, inst_valid_id, fetch_busy;
    fetch_state_t state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc_110 = 0;
    int mem_lat  = 1;
    logic [31:0] mem_addr_q[$];
    int          mem_cnt_q[$];

    // model: addresses in flight, next address to fetch, parked response, ID regs
    logic [31:0] exp_q[$];
    logic [31:0] m_fetch_pc, m_park_inst, m_park_pc, m_id_inst, m_id_pc;
    logic        m_boot, m_stale, m_parked, m_id_v;

    ama_riscv_fetch dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_we(pc_we),
        .stall_if(stall_if), .clear_if(clear_if), .alu_out(alu_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_id(inst_id), .pc_id(pc_id), .inst_valid_id(inst_valid_id),
        .fetch_busy(fetch_busy), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fetch_pc = RESET_VEC;
        m_boot     = 1'b1;
        m_stale    = 1'b0;
        m_parked   = 1'b0;
        m_id_inst  = NOP;
        m_id_pc    = 32'h0;
        m_id_v     = 1'b0;
    endtask

    // Compare the current cycle against the model, then advance the model.
    task automatic model_cycle();
        logic redir, rsp_here, rsp_good, may_issue, e_req, e_busy;
        logic [31:0] tgt, e_addr, head;
        fetch_state_t e_state;
        redir    = pc_we && (pc_sel == 2'd1 || pc_sel == 2'd3);
        tgt      = (pc_sel == 2'd3) ? RESET_VEC : (alu_out & 32'hFFFF_FFFC);
        rsp_here = (exp_q.size() != 0) && imem_rvalid;
        rsp_good = rsp_here && !m_stale;
        head     = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
        may_issue = !m_boot && !m_parked &&
                    ((exp_q.size() == 0) || (rsp_good && (clear_if || !stall_if)));
        e_req    = !rst && pc_we && may_issue;
        e_addr   = redir ? tgt : m_fetch_pc;
        e_busy   = !(rsp_good || m_parked) && !stall_if;
        e_state  = m_boot ? FETCH_RST : m_parked ? FETCH_HOLD :
                   (exp_q.size() != 0) ? FETCH_WAIT : FETCH_REQ;

        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("fetch_busy", 32'(fetch_busy), 32'(e_busy));
        chk("inst_id", inst_id, m_id_inst);
        chk("pc_id", pc_id, m_id_pc);
        chk("inst_valid_id", 32'(inst_valid_id), 32'(m_id_v));
        chk("state", 32'(state_dbg), 32'(e_state));

        if (rst) begin
            model_reset();
            return;
        end

        if (clear_if) begin
            m_id_inst = NOP; m_id_v = 1'b0;
        end else if (!stall_if) begin
            if (rsp_good) begin
                m_id_inst = imem_rdata; m_id_pc = head; m_id_v = 1'b1;
            end else if (m_parked && !redir) begin
                m_id_inst = m_park_inst; m_id_pc = m_park_pc; m_id_v = 1'b1;
            end else begin
                m_id_inst = NOP; m_id_v = 1'b0;
            end
        end

        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_parked) begin
            if (redir) begin
                m_parked = 1'b0; m_fetch_pc = tgt;
            end else if (clear_if || !stall_if) begin
                m_parked = 1'b0;
            end
        end else begin
            if (rsp_here) begin
                void'(exp_q.pop_front());
                if (m_stale) begin
                    m_stale = 1'b0;
                    if (redir) m_fetch_pc = tgt;
                end else if (!clear_if && stall_if) begin
                    if (redir) m_fetch_pc = tgt;
                    else begin
                        m_parked = 1'b1; m_park_inst = imem_rdata; m_park_pc = head;
                    end
                end
            end else if (exp_q.size() != 0 && redir) begin
                m_stale = 1'b1; m_fetch_pc = tgt;
            end
            if (e_req) begin
                if (imem_ready) begin
                    exp_q.push_back(e_addr); m_fetch_pc = e_addr + 32'd4;
                end else begin
                    m_fetch_pc = e_addr;
                end
            end
        end
    endtask

    // One clock: check at negedge, memory responds just after posedge.
    task automatic cycle();
        logic acc, rsp;
        logic [31:0] acc_addr;
        @(negedge clk);
        model_cycle();
        acc = imem_req && imem_ready;
        acc_addr = imem_addr;
        rsp = imem_rvalid;
        if (acc && acc_addr == 32'h110) n_acc_110++;
        @(posedge clk);
        #1;
        if (rsp && mem_addr_q.size() != 0) begin
            void'(mem_addr_q.pop_front());
            void'(mem_cnt_q.pop_front());
        end
        if (acc) begin
            mem_addr_q.push_back(acc_addr);
            mem_cnt_q.push_back(mem_lat);
        end
        if (mem_addr_q.size() != 0 && mem_cnt_q[0] <= 1) begin
            imem_rvalid = 1'b1; imem_rdata = mem_addr_q[0];
        end else begin
            if (mem_cnt_q.size() != 0) mem_cnt_q[0] = mem_cnt_q[0] - 1;
            imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    initial begin
        logic [15:0] stall_pat;
        stall_pat = 16'b0011_0100_0110_0001;
        rst = 1'b1; pc_we = 1'b1; pc_sel = 2'd0; stall_if = 1'b0; clear_if = 1'b0;
        alu_out = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle(); cycle();

        // reset release and streaming at one instruction per cycle
        rst = 1'b0; #1;
        chk("pin_rst_state", 32'(state_dbg), 32'(FETCH_RST));
        chk("pin_rst_req", 32'(imem_req), 32'h0);
        chk("pin_rst_inst", inst_id, NOP);
        chk("pin_rst_pcid", pc_id, 32'h0);
        chk("pin_rst_valid", 32'(inst_valid_id), 32'h0);
        cycle(); #1;
        chk("pin_first_req", 32'(imem_req), 32'h1);
        chk("pin_first_addr", imem_addr, 32'h0);
        chk("pin_first_busy", 32'(fetch_busy), 32'h1);
        cycle(); cycle(); #1;
        chk("pin_inst0", inst_id, 32'h0);
        chk("pin_valid0", 32'(inst_valid_id), 32'h1);
        cycle(); #1;
        chk("pin_inst4", inst_id, 32'h4);

        // stall while the response for 0x8 arrives
        stall_if = 1'b1; #1;
        chk("pin_stall_noreq", 32'(imem_req), 32'h0);
        cycle(); #1;
        chk("pin_hold_state", 32'(state_dbg), 32'(FETCH_HOLD));
        chk("pin_hold_inst", inst_id, 32'h4);
        cycle(); cycle();
        stall_if = 1'b0;
        cycle(); #1;
        chk("pin_release_inst", inst_id, 32'h8);
        chk("pin_release_addr", imem_addr, 32'hC);
        cycle();
        mem_lat = 4;

        // redirect while 0x10 is outstanding
        cycle();
        pc_sel = 2'd1; alu_out = 32'h100; #1;
        chk("pin_redir_noreq", 32'(imem_req), 32'h0);
        cycle();
        pc_sel = 2'd0; mem_lat = 1;
        cycle(); cycle(); cycle(); #1;
        chk("pin_redir_addr", imem_addr, 32'h100);
        chk("pin_redir_valid", 32'(inst_valid_id), 32'h0);
        cycle(); cycle(); #1;
        chk("pin_redir_inst", inst_id, 32'h100);
        chk("pin_redir_pcid", pc_id, 32'h100);

        // clear coincident with a response
        clear_if = 1'b1; #1;
        chk("pin_clear_addr", imem_addr, 32'h108);
        cycle();
        clear_if = 1'b0; #1;
        chk("pin_clear_inst", inst_id, NOP);
        chk("pin_clear_valid", 32'(inst_valid_id), 32'h0);
        cycle(); #1;
        chk("pin_after_clear", inst_id, 32'h108);

        // imem_ready low for five cycles
        imem_ready = 1'b0;
        cycle(); cycle(); #1;
        chk("pin_nr_req", 32'(imem_req), 32'h1);
        chk("pin_nr_addr", imem_addr, 32'h110);
        chk("pin_nr_busy", 32'(fetch_busy), 32'h1);
        chk("pin_nr_inst", inst_id, NOP);
        cycle(); cycle(); cycle();
        imem_ready = 1'b1; mem_lat = 2;
        cycle();

        // reset during WAIT with a stale response right after
        rst = 1'b1;
        cycle();
        rst = 1'b0; mem_lat = 1; #1;
        chk("pin_rst2_state", 32'(state_dbg), 32'(FETCH_RST));
        cycle(); #1;
        chk("pin_rst2_addr", imem_addr, RESET_VEC);
        chk("pin_acc_110", 32'(n_acc_110), 32'h1);
        cycle(); cycle(); #1;
        chk("pin_rst2_inst", inst_id, 32'h0);

        // misaligned target, PC wrap, reserved select, RESET_VEC select, pc_we=0
        pc_sel = 2'd1; alu_out = 32'hFFFF_FFFF; #1;
        chk("pin_align_addr", imem_addr, 32'hFFFF_FFFC);
        cycle();
        pc_sel = 2'd0; #1;
        chk("pin_wrap_addr", imem_addr, 32'h0);
        cycle(); #1;
        chk("pin_wrap_inst", inst_id, 32'hFFFF_FFFC);
        pc_sel = 2'd2; alu_out = 32'h500; #1;
        chk("pin_bp_addr", imem_addr, 32'h4);
        cycle();
        pc_sel = 2'd3; #1;
        chk("pin_start_addr", imem_addr, RESET_VEC);
        cycle();
        pc_sel = 2'd0; pc_we = 1'b0; #1;
        chk("pin_we0_req", 32'(imem_req), 32'h0);
        cycle(); cycle();
        pc_we = 1'b1; #1;
        chk("pin_we1_addr", imem_addr, 32'h4);

        // stall pattern with a redirect, two-cycle memory
        mem_lat = 2;
        for (int i = 0; i < 16; i++) begin
            stall_if = stall_pat[i];
            pc_sel   = (i == 9) ? 2'd1 : 2'd0;
            alu_out  = 32'h240;
            cycle();
        end
        stall_if = 1'b0; pc_sel = 2'd0;
        repeat (6) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
